// File: rtl/seq_lock_fsm.sv
// Button-sequence lock: edge-detected presses are compared live against `code`.
// Repeated failures lead to a timed lockout.
module seq_lock_fsm #(
    parameter int NB          = 3,
    parameter int LEN         = 4,
    parameter int TIMEOUT     = 16,
    parameter int OPEN_CYCLES = 8,
    parameter int MAX_FAIL    = 3,
    parameter int LOCK_CYCLES = 32
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NB:1]                       b,
    input  logic [LEN*NB-1:0]                 code,
    output logic                              outp,
    output logic                              locked,
    output logic [$clog2(MAX_FAIL+1)-1:0]     fail_cnt,
    output logic [2:0]                        state_o
);

    localparam int IW   = $clog2(LEN);
    localparam int TW   = $clog2(TIMEOUT);
    localparam int FW   = $clog2(MAX_FAIL + 1);
    localparam int CMAX = (OPEN_CYCLES > LOCK_CYCLES) ? OPEN_CYCLES : LOCK_CYCLES;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTRY   = 3'd1,
        OPEN    = 3'd2,
        FAIL    = 3'd3,
        LOCKOUT = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [FW-1:0] fail_q, fail_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [NB:1]   b_q;
    logic          run_q;

    logic          press;
    logic [NB-1:0] elem;
    logic          mism;

    // run_q masks the first clock after reset so a button already held is not a press.
    assign press = run_q && (b != '0) && (b_q == '0);

    // idx_q is zero whenever the FSM is in IDLE, so this also selects element 0 there.
    always_comb begin
        elem = '0;
        for (int k = 0; k < LEN; k++) begin
            if (idx_q == IW'(k)) elem = code[k*NB +: NB];
        end
    end

    assign mism = (b != elem) || (elem == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= '0;
            fail_q  <= '0;
            cnt_q   <= '0;
            b_q     <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            fail_q  <= fail_d;
            cnt_q   <= cnt_d;
            b_q     <= b;
            run_q   <= 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        err_d   = err_q;
        timer_d = timer_q;
        fail_d  = fail_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (press) begin
                    state_d = ENTRY;
                    idx_d   = IW'(1);
                    err_d   = mism;
                    timer_d = '0;
                end
            end
            ENTRY: begin
                if (press) begin
                    timer_d = '0;
                    if (idx_q != IW'(LEN - 1)) begin
                        err_d = err_q | mism;
                        idx_d = idx_q + IW'(1);
                    end else begin
                        idx_d = '0;
                        if (!err_q && !mism) begin
                            state_d = OPEN;
                            cnt_d   = CW'(OPEN_CYCLES - 1);
                            fail_d  = '0;
                        end else begin
                            state_d = FAIL;
                        end
                    end
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    state_d = FAIL;
                    idx_d   = '0;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            OPEN: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CW'(1);
            end
            FAIL: begin
                if (fail_q == FW'(MAX_FAIL - 1)) begin
                    state_d = LOCKOUT;
                    fail_d  = FW'(MAX_FAIL);
                    cnt_d   = CW'(LOCK_CYCLES - 1);
                end else begin
                    state_d = IDLE;
                    fail_d  = fail_q + FW'(1);
                end
            end
            LOCKOUT: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    fail_d  = '0;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign outp     = (state_q == OPEN);
    assign locked   = (state_q == LOCKOUT);
    assign fail_cnt = fail_q;
    assign state_o  = state_q;

endmodule

// File: tb/tb_seq_lock_fsm.sv
// Bench for seq_lock_fsm at default parameters: a per-cycle reference model feeds an
// expected-output queue, plus hand-derived checks on durations and key transitions.
module tb_seq_lock_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:1]  b;
    logic [11:0] code;
    logic        outp, locked;
    logic [1:0]  fail_cnt;
    logic [2:0]  state_o;

    seq_lock_fsm dut (
        .clk      (clk),
        .rst      (rst),
        .b        (b),
        .code     (code),
        .outp     (outp),
        .locked   (locked),
        .fail_cnt (fail_cnt),
        .state_o  (state_o)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic [6:0] exp_q[$];

    int       m_st, m_idx, m_timer, m_cnt, m_fail;
    bit       m_err, m_first;
    logic [2:0] m_bq;

    int outp_cycles, locked_cycles, fail_visits, entry_starts;
    logic [2:0] prev_state;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] elem(input int k);
        return code[k*3 +: 3];
    endfunction

    task automatic model_reset();
        m_st = 0; m_idx = 0; m_timer = 0; m_cnt = 0; m_fail = 0;
        m_err = 0; m_first = 1; m_bq = 3'd0;
    endtask

    task automatic model_step(input logic [2:0] bv);
        logic [2:0] e;
        bit press, mm;
        e     = elem((m_st == 1) ? m_idx : 0);
        press = !m_first && (bv != 3'd0) && (m_bq == 3'd0);
        mm    = (bv != e) || (e == 3'd0);
        m_first = 0;
        m_bq    = bv;
        case (m_st)
            0: if (press) begin m_st = 1; m_idx = 1; m_err = mm; m_timer = 0; end
            1: begin
                if (press) begin
                    m_timer = 0;
                    if (m_idx < 3) begin
                        m_err = m_err | mm;
                        m_idx++;
                    end else begin
                        m_idx = 0;
                        if (!m_err && !mm) begin m_st = 2; m_cnt = 8; m_fail = 0; end
                        else m_st = 3;
                    end
                end else if (m_timer == 15) begin
                    m_st = 3; m_idx = 0; m_timer = 0;
                end else begin
                    m_timer++;
                end
            end
            2: begin m_cnt--; if (m_cnt == 0) m_st = 0; end
            3: begin
                m_fail++;
                if (m_fail == 3) begin m_st = 4; m_cnt = 32; end
                else m_st = 0;
            end
            4: begin m_cnt--; if (m_cnt == 0) begin m_st = 0; m_fail = 0; end end
            default: m_st = 0;
        endcase
    endtask

    // One clock: drive b, predict, then compare on the far side of the edge.
    task automatic tick(input logic [2:0] bv);
        b = bv;
        model_step(bv);
        exp_q.push_back({3'(m_st), m_st == 2, m_st == 4, 2'(m_fail)});
        @(posedge clk);
        #1;
        check("cycle", {state_o, outp, locked, fail_cnt}, exp_q.pop_front());
        if (outp) outp_cycles++;
        if (locked) locked_cycles++;
        if (state_o == 3'd3) fail_visits++;
        if (state_o == 3'd1 && prev_state != 3'd1) entry_starts++;
        prev_state = state_o;
    endtask

    task automatic do_reset(input logic [2:0] bv);
        rst = 1'b1;
        b   = bv;
        @(posedge clk);
        #1;
        check("reset_outputs", {state_o, outp, locked, fail_cnt}, 7'd0);
        model_reset();
        exp_q.delete();
        prev_state = 3'd0;
        rst = 1'b0;
    endtask

    task automatic seq4(input logic [2:0] p0, input logic [2:0] p1, input logic [2:0] p2,
                        input logic [2:0] p3, input int hold, input int gap);
        logic [2:0] ps[4];
        ps[0] = p0; ps[1] = p1; ps[2] = p2; ps[3] = p3;
        for (int i = 0; i < 4; i++) begin
            repeat (hold) tick(ps[i]);
            repeat (gap) tick(3'd0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) tick(3'd0);
    endtask

    initial begin
        code = 12'h711;
        b    = 3'd0;
        rst  = 1'b0;
        prev_state = 3'd0;
        #2;
        do_reset(3'd0);

        // Correct code opens on the edge of the 4th press, for 8 cycles
        outp_cycles = 0;
        tick(3'd0);
        seq4(3'd1, 3'd2, 3'd4, 3'd0, 2, 2);
        tick(3'd3);
        check("open_on_4th_press", state_o, 3'd2);
        tick(3'd3);
        idle(12);
        check("open_length", outp_cycles, 8);
        check("open_fail_cnt", fail_cnt, 0);

        // Wrong code: one FAIL cycle, fail_cnt 1, never opens
        do_reset(3'd0);
        fail_visits = 0; outp_cycles = 0;
        tick(3'd0);
        seq4(3'd1, 3'd4, 3'd4, 3'd3, 2, 2);
        idle(4);
        check("wrong_fail_visits", fail_visits, 1);
        check("wrong_fail_cnt", fail_cnt, 1);
        check("wrong_no_open", outp_cycles, 0);

        // Three failures lock out for 32 cycles, presses ignored meanwhile
        do_reset(3'd0);
        locked_cycles = 0;
        tick(3'd0);
        repeat (3) seq4(3'd2, 3'd2, 3'd2, 3'd2, 1, 1);
        check("lockout_locked", locked, 1);
        check("lockout_fail_cnt", fail_cnt, 3);
        repeat (30) tick(3'($urandom_range(0, 7)));
        idle(10);
        check("lockout_length", locked_cycles, 32);
        check("after_lockout_state", state_o, 3'd0);
        check("after_lockout_fail_cnt", fail_cnt, 0);
        outp_cycles = 0;
        seq4(3'd1, 3'd2, 3'd4, 3'd3, 2, 2);
        idle(10);
        check("open_after_lockout", outp_cycles, 8);

        // Timeout after 16 idle cycles
        do_reset(3'd0);
        tick(3'd0);
        tick(3'd1);
        idle(15);
        check("timeout_not_yet", state_o, 3'd1);
        tick(3'd0);
        check("timeout_fail", state_o, 3'd3);
        tick(3'd0);
        check("timeout_fail_cnt", fail_cnt, 1);

        // Press arriving on the expiry cycle wins every time
        do_reset(3'd0);
        tick(3'd0);
        tick(3'd1); idle(15);
        tick(3'd2); idle(15);
        tick(3'd4); idle(15);
        tick(3'd3);
        check("press_beats_timeout", state_o, 3'd2);
        idle(10);

        // A held button is one press only
        do_reset(3'd0);
        entry_starts = 0;
        tick(3'd0);
        repeat (40) tick(3'd1);
        tick(3'd0);
        check("held_single_press", entry_starts, 1);

        // Button already down at reset release is not a press
        do_reset(3'd1);
        repeat (3) tick(3'd1);
        check("no_press_after_reset", state_o, 3'd0);

        // Code is sampled live at each press
        do_reset(3'd0);
        tick(3'd0);
        tick(3'd1); tick(3'd0);
        tick(3'd2); tick(3'd0);
        code = 12'h751;
        tick(3'd5); tick(3'd0);
        tick(3'd3);
        check("live_code_open", state_o, 3'd2);
        idle(10);
        code = 12'h711;

        // Asynchronous reset mid-entry with a nonzero failure count
        do_reset(3'd0);
        tick(3'd0);
        seq4(3'd1, 3'd4, 3'd4, 3'd3, 1, 1);
        idle(2);
        tick(3'd1); tick(3'd0); tick(3'd2);
        #3;
        rst = 1'b1;
        #1;
        check("async_reset", {state_o, outp, locked, fail_cnt}, 7'd0);
        @(posedge clk);
        #1;
        model_reset();
        exp_q.delete();
        prev_state = 3'd0;
        rst = 1'b0;
        idle(3);
        check("after_async_reset", state_o, 3'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
